// File: rtl/present_pkg.sv
// -----------------------------------------------------------------------------
// present_pkg
// Shared definitions for the PRESENT substitution layer:
//   SBOX_FWD / SBOX_INV : 16-entry 4-bit forward and inverse S-box tables,
//                         indexed by the input nibble value.
//   MODE_FWD / MODE_INV : encodings of the substitution direction.
//   state_e             : control FSM states of sbox_layer_seq.
// -----------------------------------------------------------------------------
package present_pkg;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;

  localparam logic [3:0] SBOX_FWD [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] SBOX_INV [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sbox_lane.sv
// -----------------------------------------------------------------------------
// sbox_lane
// One PRESENT S-box lane, purely combinational.
// Ports:
//   nibble  in  4  nibble to substitute
//   mode    in  1  MODE_FWD = forward S-box, MODE_INV = inverse S-box
//   result  out 4  substituted nibble
// -----------------------------------------------------------------------------
module sbox_lane
  import present_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       mode,
  output logic [3:0] result
);

  // Table lookup in the direction selected by mode.
  always_comb begin
    result = 4'h0;
    if (mode == MODE_INV) begin
      result = SBOX_INV[nibble];
    end else begin
      result = SBOX_FWD[nibble];
    end
  end

endmodule

// File: rtl/sbox_layer_seq.sv
// -----------------------------------------------------------------------------
// sbox_layer_seq
// Time-multiplexed PRESENT substitution layer. A STATE_WIDTH-bit state is
// loaded into a rotating register; every BUSY cycle the lowest LANES nibbles
// are substituted and the register is rotated right by 4*LANES bits, so after
// N = STATE_WIDTH/(4*LANES) cycles every nibble has been substituted once and
// is back in its original position.
// Ports:
//   Clk_ik    in  1            clock, rising edge
//   Rst_iran  in  1            asynchronous active-low reset
//   Data_ib   in  STATE_WIDTH  input state, nibble k = bits [4k+3:4k]
//   Mode_i    in  1            0 forward / 1 inverse, sampled at accept
//   Valid_i   in  1            input valid
//   Ready_o   out 1            block can accept a new state (registered)
//   Data_ob   out STATE_WIDTH  substituted state (holds last result)
//   Valid_o   out 1            Data_ob valid
//   Ready_i   in  1            downstream accepts Data_ob
//   Busy_o    out 1            substitution in progress
// -----------------------------------------------------------------------------
module sbox_layer_seq
  import present_pkg::*;
#(
  parameter int STATE_WIDTH = 64,
  parameter int LANES       = 4
) (
  input  logic                   Clk_ik,
  input  logic                   Rst_iran,
  input  logic [STATE_WIDTH-1:0] Data_ib,
  input  logic                   Mode_i,
  input  logic                   Valid_i,
  output logic                   Ready_o,
  output logic [STATE_WIDTH-1:0] Data_ob,
  output logic                   Valid_o,
  input  logic                   Ready_i,
  output logic                   Busy_o
);

  // Guarded so that an illegal LANES value still reaches the $error below
  // instead of dividing by zero first.
  localparam int LANE_BITS = 4 * ((LANES > 0) ? LANES : 1);
  localparam int N_CYCLES  = STATE_WIDTH / LANE_BITS;
  localparam int CNT_W     = (N_CYCLES > 1) ? $clog2(N_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  generate
    if (LANES < 1 || LANES > STATE_WIDTH / 4) begin : g_bad_lanes
      $error("sbox_layer_seq: LANES must be in 1..STATE_WIDTH/4");
    end else if ((STATE_WIDTH % LANE_BITS) != 0) begin : g_bad_width
      $error("sbox_layer_seq: STATE_WIDTH must be a multiple of 4*LANES");
    end
  endgenerate

  state_e                 state_r, state_s;
  logic [STATE_WIDTH-1:0] shift_r, shift_s;
  logic                   mode_r, mode_s;
  logic [CNT_W-1:0]       cnt_r, cnt_s;
  logic [STATE_WIDTH-1:0] data_r, data_s;
  logic                   ready_r, ready_s;
  logic                   valid_r, valid_s;
  logic                   busy_r, busy_s;

  logic [LANE_BITS-1:0]   sub_s;
  logic [STATE_WIDTH-1:0] rot_s;

  // S-box lanes work on the lowest nibbles of the rotating register.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sbox_lane u_lane (
      .nibble (shift_r[4*i +: 4]),
      .mode   (mode_r),
      .result (sub_s[4*i +: 4])
    );
  end

  // Substituted low nibbles go to the top: a right rotation by 4*LANES bits.
  // In the full-parallel case there is nothing left to rotate.
  if (LANE_BITS == STATE_WIDTH) begin : g_rot_full
    assign rot_s = sub_s;
  end else begin : g_rot_part
    assign rot_s = {sub_s, shift_r[STATE_WIDTH-1:LANE_BITS]};
  end

  // Next-state, datapath and next-output logic of the control FSM.
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    mode_s  = mode_r;
    cnt_s   = cnt_r;
    data_s  = data_r;
    case (state_r)
      ST_IDLE: begin
        // ready_r is low on the very first cycle after reset, so no accept
        // can happen before Ready_o has been seen high.
        if (Valid_i && ready_r) begin
          state_s = ST_BUSY;
          shift_s = Data_ib;
          mode_s  = Mode_i;
          cnt_s   = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        shift_s = rot_s;
        cnt_s   = cnt_r + CNT_ONE;
        if (cnt_r == CNT_LAST) begin
          state_s = ST_DONE;
          data_s  = rot_s;
        end else begin
          state_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (Ready_i) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    // Outputs are registered copies of what the next state implies, so they
    // change on the same edge as the FSM.
    ready_s = (state_s == ST_IDLE);
    valid_s = (state_s == ST_DONE);
    busy_s  = (state_s == ST_BUSY);
  end

  // State, datapath and output registers.
  always_ff @(posedge Clk_ik or negedge Rst_iran) begin
    if (!Rst_iran) begin
      state_r <= ST_IDLE;
      shift_r <= '0;
      mode_r  <= MODE_FWD;
      cnt_r   <= '0;
      data_r  <= '0;
      ready_r <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      shift_r <= shift_s;
      mode_r  <= mode_s;
      cnt_r   <= cnt_s;
      data_r  <= data_s;
      ready_r <= ready_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
    end
  end

  assign Ready_o = ready_r;
  assign Valid_o = valid_r;
  assign Busy_o  = busy_r;
  assign Data_ob = data_r;

endmodule

// File: tb/tb_sbox_layer_seq.sv
// -----------------------------------------------------------------------------
// tb_sbox_layer_seq
// Self-checking bench for sbox_layer_seq. Four instances (LANES = 4, 1, 2, 16)
// share clock and reset. Expected results come from a nibble-wise table model;
// the inverse table is derived by inverting the forward table.
// -----------------------------------------------------------------------------
module tb_sbox_layer_seq;

  localparam int SW   = 64;
  localparam int NDUT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [SW-1:0] din     [NDUT];
  logic          mode_in [NDUT];
  logic          vin     [NDUT];
  logic          rdy_out [NDUT];
  logic [SW-1:0] dout    [NDUT];
  logic          vout    [NDUT];
  logic          rdy_in  [NDUT];
  logic          busy    [NDUT];

  int errors = 0;
  int checks = 0;

  logic [3:0] fwd_t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                             4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [3:0] inv_t [16];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int L = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 16;
    sbox_layer_seq #(.STATE_WIDTH(SW), .LANES(L)) u_dut (
      .Clk_ik   (clk),
      .Rst_iran (rst_n),
      .Data_ib  (din[g]),
      .Mode_i   (mode_in[g]),
      .Valid_i  (vin[g]),
      .Ready_o  (rdy_out[g]),
      .Data_ob  (dout[g]),
      .Valid_o  (vout[g]),
      .Ready_i  (rdy_in[g]),
      .Busy_o   (busy[g])
    );
  end

  function automatic int lanes_of(input int s);
    case (s)
      0: return 4;
      1: return 1;
      2: return 2;
      default: return 16;
    endcase
  endfunction

  function automatic logic [SW-1:0] ref_layer(input logic [SW-1:0] x, input logic inv);
    logic [SW-1:0] y;
    y = '0;
    for (int k = 0; k < SW / 4; k++) begin
      y[4*k +: 4] = inv ? inv_t[x[4*k +: 4]] : fwd_t[x[4*k +: 4]];
    end
    return y;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transfer with Ready_i=1. lat counts edges from the accept edge
  // (inclusive) to the edge after which Valid_o is first seen; -1 on timeout.
  task automatic do_xfer(input int s, input logic [SW-1:0] d, input logic m,
                         output logic [SW-1:0] res, output int lat, output int busy_n);
    int guard;
    res = '0; lat = -1; busy_n = 0; guard = 0;
    rdy_in[s] = 1'b1;
    while (rdy_out[s] !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    din[s] = d; mode_in[s] = m; vin[s] = 1'b1;
    tick();
    vin[s] = 1'b0; din[s] = {$urandom, $urandom}; mode_in[s] = 1'($urandom);
    for (int c = 2; c < 60; c++) begin
      if (busy[s] === 1'b1) busy_n++;
      tick();
      if (vout[s] === 1'b1) begin
        lat = c;
        res = dout[s];
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    for (int s = 0; s < NDUT; s++) begin
      checks++;
      if ({rdy_out[s], vout[s], busy[s], dout[s]} !== {3'b000, 64'h0}) begin
        errors++;
        $display("FAIL reset_state dut%0d: got rdy=%b v=%b busy=%b data=%h required all zero",
                 s, rdy_out[s], vout[s], busy[s], dout[s]);
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (rdy_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: got %b required 0", rdy_out[0]);
    end
    tick();
    for (int s = 0; s < NDUT; s++) begin
      checks++;
      if (rdy_out[s] !== 1'b1) begin
        errors++;
        $display("FAIL ready_after_release dut%0d: got %b required 1", s, rdy_out[s]);
      end
    end
  endtask

  task automatic test_zero();
    logic [SW-1:0] res;
    int lat, bn;
    do_xfer(0, 64'h0, 1'b0, res, lat, bn);
    checks++;
    if (res !== 64'hCCCC_CCCC_CCCC_CCCC) begin
      errors++;
      $display("FAIL zero_fwd: got %h required %h", res, 64'hCCCC_CCCC_CCCC_CCCC);
    end
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL zero_latency: got %0d required 5", lat);
    end
    checks++;
    if (bn !== 4) begin
      errors++;
      $display("FAIL zero_busy_cycles: got %0d required 4", bn);
    end
  endtask

  task automatic test_known();
    logic [SW-1:0] res, back;
    int lat, bn;
    do_xfer(0, 64'h0123_4567_89AB_CDEF, 1'b0, res, lat, bn);
    checks++;
    if (res !== 64'hC56B_90AD_3EF8_4712) begin
      errors++;
      $display("FAIL known_fwd: got %h required %h", res, 64'hC56B_90AD_3EF8_4712);
    end
    do_xfer(0, res, 1'b1, back, lat, bn);
    checks++;
    if (back !== 64'h0123_4567_89AB_CDEF) begin
      errors++;
      $display("FAIL known_inv: got %h required %h", back, 64'h0123_4567_89AB_CDEF);
    end
  endtask

  task automatic test_stall();
    logic [SW-1:0] d, held, want;
    logic m;
    int guard;
    d = {$urandom, $urandom}; m = 1'($urandom);
    want = ref_layer(d, m);
    rdy_in[0] = 1'b0;
    guard = 0;
    while (rdy_out[0] !== 1'b1 && guard < 50) begin tick(); guard++; end
    din[0] = d; mode_in[0] = m; vin[0] = 1'b1;
    tick();
    vin[0] = 1'b0;
    guard = 0;
    while (vout[0] !== 1'b1 && guard < 50) begin tick(); guard++; end
    held = dout[0];
    checks++;
    if (held !== want) begin
      errors++;
      $display("FAIL stall_result: got %h required %h", held, want);
    end
    for (int c = 0; c < 7; c++) begin
      vin[0] = 1'b1; din[0] = {SW{1'b1}}; mode_in[0] = 1'($urandom);
      tick();
      checks++;
      if ({vout[0], rdy_out[0], busy[0], dout[0]} !== {3'b100, held}) begin
        errors++;
        $display("FAIL stall_hold c%0d: got v=%b rdy=%b busy=%b data=%h required v=1 rdy=0 busy=0 data=%h",
                 c, vout[0], rdy_out[0], busy[0], dout[0], held);
      end
    end
    vin[0] = 1'b0;
    rdy_in[0] = 1'b1;
    tick();
    checks++;
    if ({vout[0], rdy_out[0], dout[0]} !== {2'b01, held}) begin
      errors++;
      $display("FAIL stall_release: got v=%b rdy=%b data=%h required v=0 rdy=1 data=%h",
               vout[0], rdy_out[0], dout[0], held);
    end
  endtask

  task automatic test_reset_mid();
    logic [SW-1:0] d, res;
    int lat, bn, guard;
    d = {$urandom, $urandom};
    rdy_in[0] = 1'b1;
    guard = 0;
    while (rdy_out[0] !== 1'b1 && guard < 50) begin tick(); guard++; end
    din[0] = d; mode_in[0] = 1'b0; vin[0] = 1'b1;
    tick();
    vin[0] = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rdy_out[0], vout[0], busy[0], dout[0]} !== {3'b000, 64'h0}) begin
      errors++;
      $display("FAIL midreset_immediate: got rdy=%b v=%b busy=%b data=%h required all zero",
               rdy_out[0], vout[0], busy[0], dout[0]);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({rdy_out[0], vout[0], busy[0], dout[0]} !== {3'b100, 64'h0}) begin
      errors++;
      $display("FAIL midreset_recover: got rdy=%b v=%b busy=%b data=%h required rdy=1 others zero",
               rdy_out[0], vout[0], busy[0], dout[0]);
    end
    do_xfer(0, d, 1'b1, res, lat, bn);
    checks++;
    if (res !== ref_layer(d, 1'b1)) begin
      errors++;
      $display("FAIL midreset_next: got %h required %h", res, ref_layer(d, 1'b1));
    end
  endtask

  task automatic test_lanes();
    logic [SW-1:0] d, res;
    int lat, bn, n;
    for (int s = 1; s < NDUT; s++) begin
      n = (SW / 4) / lanes_of(s);
      for (int k = 0; k < 4; k++) begin
        d = {$urandom, $urandom};
        do_xfer(s, d, 1'(k), res, lat, bn);
        checks++;
        if (res !== ref_layer(d, 1'(k))) begin
          errors++;
          $display("FAIL lanes%0d_data k%0d: got %h required %h", lanes_of(s), k, res, ref_layer(d, 1'(k)));
        end
        checks++;
        if (lat !== n + 1) begin
          errors++;
          $display("FAIL lanes%0d_latency k%0d: got %0d required %0d", lanes_of(s), k, lat, n + 1);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0] exp_q [$];
    logic [SW-1:0] d;
    int nres, last_v, acc;
    nres = 0; last_v = -1; acc = 0;
    rdy_in[0] = 1'b1;
    vin[0] = 1'b1;
    for (int cyc = 0; cyc < 200 && nres < 6; cyc++) begin
      if (rdy_out[0] === 1'b1) begin
        d = {$urandom, $urandom};
        din[0] = d; mode_in[0] = 1'(acc);
        exp_q.push_back(ref_layer(d, 1'(acc)));
        acc++;
      end else begin
        din[0] = {$urandom, $urandom}; mode_in[0] = 1'($urandom);
      end
      tick();
      if (vout[0] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_data r%0d: got %h required none pending", nres, dout[0]);
        end else begin
          if (dout[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL b2b_data r%0d: got %h required %h", nres, dout[0], exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        if (last_v >= 0) begin
          checks++;
          if (cyc - last_v != 6) begin
            errors++;
            $display("FAIL b2b_interval r%0d: got %0d required 6", nres, cyc - last_v);
          end
        end
        last_v = cyc;
        nres++;
      end
    end
    vin[0] = 1'b0;
    checks++;
    if (nres != 6) begin
      errors++;
      $display("FAIL b2b_count: got %0d required 6", nres);
    end
    tick();
  endtask

  initial begin
    for (int v = 0; v < 16; v++) inv_t[fwd_t[v]] = 4'(v);
    for (int s = 0; s < NDUT; s++) begin
      din[s] = '0; mode_in[s] = 1'b0; vin[s] = 1'b0; rdy_in[s] = 1'b1;
    end
    rst_n = 1'b0;
    test_reset();
    test_zero();
    test_known();
    test_stall();
    test_reset_mid();
    test_lanes();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
